// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the SLURM32 fetch stage.
//   NOP_INSTRUCTION      word presented when no instruction is valid
//   PC_INCREMENT         byte step between sequential fetches
//   DEFAULT_RESET_VECTOR default first fetch address
//   fetchState_t         fetch FSM state encoding
package cpu_fetch_pkg;

   localparam logic [31:0] NOP_INSTRUCTION      = 32'h0;
   localparam int unsigned PC_INCREMENT         = 4;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0;

   typedef enum logic [0:0] {
      RST_WAIT = 1'b0,
      RUN      = 1'b1
   } fetchState_t;

endpackage

// File: rtl/cpu_fetch_queue.sv
// Prefetch queue: synchronous FIFO of {pc, instruction} entries.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   flush           discard all entries (wins over push/pop)
//   push, pushData  write one entry
//   pop             drop the head entry
//   popData         head entry (meaningful when !empty)
//   empty           no entries held
//   count           number of entries held (0..DEPTH)
module cpu_fetch_queue #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         pushData,
   input  logic                     pop,
   output logic [WIDTH-1:0]         popData,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

   logic [WIDTH-1:0] entries [DEPTH];
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W-1:0] wrPtr;
   logic             full;

   assign empty   = (count == '0);
   assign full    = (count == FULL_COUNT);
   assign popData = entries[rdPtr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else if (flush) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + PTR_ONE;
         if (pop)  rdPtr <= rdPtr + PTR_ONE;
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) entries[wrPtr] <= pushData;
   end

   // The fetch credit rule must make overflow impossible.
   noOverflow: assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && !flush && full));

endmodule

// File: rtl/cpu_fetch.sv
// SLURM32 instruction fetch/prefetch stage (feeds cpu_decode).
// Issues in-order reads, buffers returns in cpu_fetch_queue, presents one
// instruction + PC per cycle, and flushes/redirects on a taken branch.
// Optional feature: define SLURM32_FETCH_BYPASS_EN to present a returning word
// combinationally when the queue is empty and nothing is being discarded.
// Ports:
//   CLK, RSTb          clock; asynchronous active-high reset
//   mem_addr           byte address of read request
//   mem_rd_req         read request, held with mem_addr until mem_ready
//   mem_ready          memory accepts request this cycle
//   mem_data           returned instruction word
//   mem_data_valid     mem_data valid (in request order)
//   stall              decode not accepting; output held
//   branch_taken       flush queue and redirect to branch_target
//   branch_target      redirect address (bits [1:0] ignored)
//   instruction        presented instruction (NOP when not valid)
//   pc_out             PC of presented instruction
//   instruction_valid  instruction/pc_out meaningful
module cpu_fetch
   import cpu_fetch_pkg::*;
#(
   parameter int unsigned BITS         = 32,
   parameter int unsigned ADDRESS_BITS = 32,
   parameter int unsigned DEPTH        = 4,
   parameter logic [ADDRESS_BITS-1:0] RESET_VECTOR = ADDRESS_BITS'(DEFAULT_RESET_VECTOR)
) (
   input  logic                    CLK,
   input  logic                    RSTb,
   output logic [ADDRESS_BITS-1:0] mem_addr,
   output logic                    mem_rd_req,
   input  logic                    mem_ready,
   input  logic [BITS-1:0]         mem_data,
   input  logic                    mem_data_valid,
   input  logic                    stall,
   input  logic                    branch_taken,
   input  logic [ADDRESS_BITS-1:0] branch_target,
   output logic [BITS-1:0]         instruction,
   output logic [ADDRESS_BITS-1:0] pc_out,
   output logic                    instruction_valid
);

   localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
   localparam int unsigned ENTRY_W = ADDRESS_BITS + BITS;
   localparam logic [CNT_W:0]        CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0]      CNT_ONE      = CNT_W'(1);
   localparam logic [ADDRESS_BITS-1:0] PC_STEP    = ADDRESS_BITS'(PC_INCREMENT);
   localparam logic [ADDRESS_BITS-1:0] ALIGN_MASK = ~ADDRESS_BITS'(3);

   fetchState_t state, stateNext;

   logic [ADDRESS_BITS-1:0] fetchPc;
   logic [ADDRESS_BITS-1:0] returnPc;   // PC of the next return that will be kept
   logic [ADDRESS_BITS-1:0] branchPc;
   logic [CNT_W-1:0]        outstanding;
   logic [CNT_W-1:0]        discard;
   logic [CNT_W-1:0]        inFlightNext;
   logic [CNT_W-1:0]        qCount;
   logic                    qEmpty;
   logic [ENTRY_W-1:0]      headEntry;
   logic                    handshake;
   logic                    dropReturn;
   logic                    bypass;
   logic                    push;
   logic                    pop;

   // ---------------- FSM ----------------
   always_ff @(posedge CLK or posedge RSTb) begin
      if (RSTb) state <= RST_WAIT;
      else      state <= stateNext;
   end

   always_comb begin
      stateNext  = state;
      mem_rd_req = 1'b0;
      unique case (state)
         RST_WAIT: stateNext = RUN;
         // Queued + in-flight words never exceed the queue size.
         RUN: mem_rd_req = (({1'b0, qCount} + {1'b0, outstanding}) < CREDIT_LIMIT);
      endcase
   end

   assign mem_addr     = fetchPc;
   assign handshake    = mem_rd_req & mem_ready;
   assign branchPc     = branch_target & ALIGN_MASK;
   assign inFlightNext = outstanding + CNT_W'(handshake) - CNT_W'(mem_data_valid);
   assign dropReturn   = mem_data_valid & (branch_taken | (discard != '0));

`ifdef SLURM32_FETCH_BYPASS_EN
   assign bypass = qEmpty & (discard == '0) & ~branch_taken & mem_data_valid;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed word consumed this cycle never enters the queue.
   assign push = mem_data_valid & ~dropReturn & ~(bypass & ~stall);
   assign pop  = ~qEmpty & ~stall & ~branch_taken;

   // ---------------- Credit / discard / PC tracking ----------------
   always_ff @(posedge CLK or posedge RSTb) begin
      if (RSTb) begin
         fetchPc     <= RESET_VECTOR;
         returnPc    <= RESET_VECTOR;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= inFlightNext;
         if (branch_taken) begin
            // Everything still in flight after this cycle belongs to the old stream.
            discard  <= inFlightNext;
            fetchPc  <= branchPc;
            returnPc <= branchPc;
         end else begin
            if (handshake) fetchPc <= fetchPc + PC_STEP;
            if (mem_data_valid) begin
               if (discard != '0) discard  <= discard - CNT_ONE;
               else               returnPc <= returnPc + PC_STEP;
            end
         end
      end
   end

   cpu_fetch_queue #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) queue (
      .clk      (CLK),
      .rst      (RSTb),
      .flush    (branch_taken),
      .push     (push),
      .pushData ({returnPc, mem_data}),
      .pop      (pop),
      .popData  (headEntry),
      .empty    (qEmpty),
      .count    (qCount)
   );

   // ---------------- Output ----------------
   always_comb begin
      instruction       = BITS'(NOP_INSTRUCTION);
      pc_out            = '0;
      instruction_valid = 1'b0;
      if (bypass) begin
         instruction       = mem_data;
         pc_out            = returnPc;
         instruction_valid = 1'b1;
      end else if (!qEmpty) begin
         instruction       = headEntry[BITS-1:0];
         pc_out            = headEntry[ENTRY_W-1:BITS];
         instruction_valid = 1'b1;
      end
   end

   noOrphanReturn: assert property (@(posedge CLK) disable iff (RSTb)
      !(mem_data_valid && outstanding == '0));

endmodule

// File: tb/tb_cpu_fetch.sv
// Self-checking bench for cpu_fetch: in-order memory model with configurable
// latency, scoreboard of expected PCs, monitor checking each consumed word.
module tb_cpu_fetch;

   logic        CLK = 1'b0;
   logic        RSTb;
   logic [31:0] mem_addr;
   logic        mem_rd_req;
   logic        mem_ready;
   logic [31:0] mem_data;
   logic        mem_data_valid;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] instruction;
   logic [31:0] pc_out;
   logic        instruction_valid;

   int          nChecks = 0;
   int          nFail   = 0;
   int          memLat  = 1;
   int          memCyc  = 0;
   int          reqCyc;
   int          validCyc;
   logic [31:0] expQ[$];
   logic [31:0] pendAddr[$];
   int          pendDue[$];
   logic [31:0] issued[$];

   always #5 CLK = ~CLK;

   cpu_fetch #(
      .BITS         (32),
      .ADDRESS_BITS (32),
      .DEPTH        (4),
      .RESET_VECTOR (32'h0)
   ) dut (
      .CLK               (CLK),
      .RSTb              (RSTb),
      .mem_addr          (mem_addr),
      .mem_rd_req        (mem_rd_req),
      .mem_ready         (mem_ready),
      .mem_data          (mem_data),
      .mem_data_valid    (mem_data_valid),
      .stall             (stall),
      .branch_taken      (branch_taken),
      .branch_target     (branch_target),
      .instruction       (instruction),
      .pc_out            (pc_out),
      .instruction_valid (instruction_valid)
   );

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return a ^ 32'hA5A5_5A5A;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Memory model: handshakes sampled mid-cycle, returns driven just after the edge.
   initial begin
      logic [31:0] a;
      int          d;
      mem_data_valid = 1'b0;
      mem_data       = '0;
      forever begin
         @(negedge CLK);
         if (RSTb) begin
            pendAddr.delete(); pendDue.delete(); issued.delete();
         end else if (mem_rd_req && mem_ready) begin
            pendAddr.push_back(mem_addr);
            pendDue.push_back(memCyc + memLat);
            issued.push_back(mem_addr);
         end
         @(posedge CLK); #1;
         memCyc++;
         if (!RSTb && pendDue.size() != 0 && pendDue[0] <= memCyc) begin
            a = pendAddr.pop_front();
            d = pendDue.pop_front();
            mem_data_valid = 1'b1;
            mem_data       = memWord(a);
         end else begin
            if (RSTb) begin pendAddr.delete(); pendDue.delete(); end
            mem_data_valid = 1'b0;
            mem_data       = '0;
         end
      end
   end

   // Monitor: every word the decoder consumes is checked against the scoreboard.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge CLK);
         if (!RSTb && instruction_valid && !stall && !branch_taken) begin
            if (expQ.size() == 0) begin
               nChecks++;
               nFail++;
               $display("FAIL unexpected_instr: got pc_out %h, required no instruction", pc_out);
            end else begin
               e = expQ.pop_front();
               check("pc_out", pc_out, e);
               check("instruction", instruction, memWord(e));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic resetCycle();
      @(posedge CLK); #2;
      RSTb = 1'b1; stall = 1'b1; branch_taken = 1'b0; mem_ready = 1'b1;
      repeat (2) begin @(posedge CLK); #2; end
      RSTb = 1'b0;
   endtask

   // Consume until the scoreboard empties; stall only changes just after an edge.
   task automatic drain(input string name, input int budget);
      int n = 0;
      @(posedge CLK); #2;
      stall = 1'b0;
      while (expQ.size() != 0 && n < budget) begin
         @(negedge CLK); #1;
         n++;
      end
      check({"drain_left_", name}, 32'(expQ.size()), 32'd0);
      expQ.delete();
      @(posedge CLK); #2;
      stall = 1'b1;
   endtask

   task automatic checkResetOutputs(input string tag);
      check({tag, "_mem_rd_req"}, 32'(mem_rd_req), 32'd0);
      check({tag, "_mem_addr"}, mem_addr, 32'h0);
      check({tag, "_instruction"}, instruction, 32'h0);
      check({tag, "_pc_out"}, pc_out, 32'h0);
      check({tag, "_valid"}, 32'(instruction_valid), 32'd0);
   endtask

   initial begin
      RSTb = 1'b1; stall = 1'b1; branch_taken = 1'b0; branch_target = '0; mem_ready = 1'b1;
      repeat (2) @(posedge CLK);
      #2;
      checkResetOutputs("rst");

      // 1: sequential fetch, 1-cycle memory
      memLat = 1;
      resetCycle();
      stall = 1'b0;
      for (int a = 0; a < 16; a += 4) expQ.push_back(32'(a));
      reqCyc = -1; validCyc = -1;
      for (int i = 0; i < 10 && validCyc < 0; i++) begin
         @(negedge CLK); #1;
         if (mem_rd_req && reqCyc < 0) reqCyc = i;
         if (instruction_valid) validCyc = i;
      end
      check("t1_first_req_cycle", 32'(reqCyc), 32'd1);
      check("t1_req_to_valid", 32'(validCyc - reqCyc), 32'd2);
      drain("t1", 40);
      for (int i = 0; i < 4; i++) check("t1_issue_addr", issued[i], 32'(4 * i));

      // 2: long stall fills credits, head held, resume contiguous
      resetCycle();
      repeat (5) begin @(negedge CLK); #1; end
      check("t2_head_early", pc_out, 32'h0);
      repeat (7) begin @(negedge CLK); #1; end
      check("t2_issued", 32'(issued.size()), 32'd4);
      check("t2_req_blocked", 32'(mem_rd_req), 32'd0);
      check("t2_valid", 32'(instruction_valid), 32'd1);
      check("t2_head_held", pc_out, 32'h0);
      for (int a = 0; a < 32; a += 4) expQ.push_back(32'(a));
      drain("t2", 60);

      // 3: 3-cycle memory, branch with two in flight
      resetCycle();
      memLat = 3; stall = 1'b0;
      expQ.push_back(32'h100); expQ.push_back(32'h104);
      repeat (3) begin @(posedge CLK); #2; end
      check("t3_inflight", 32'(issued.size()), 32'd2);
      mem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h100;
      @(posedge CLK); #2;
      branch_taken = 1'b0; mem_ready = 1'b1; #1;
      check("t3_redirect_addr", mem_addr, 32'h100);
      drain("t3", 40);

      // 4: target alignment and address wrap
      resetCycle();
      memLat = 1; stall = 1'b0; mem_ready = 1'b0;
      @(posedge CLK); #2;
      branch_taken = 1'b1; branch_target = 32'h103;
      @(posedge CLK); #2;
      branch_taken = 1'b0; #1;
      check("t4_align_addr", mem_addr, 32'h100);
      check("t4_req", 32'(mem_rd_req), 32'd1);
      branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
      @(posedge CLK); #2;
      branch_taken = 1'b0; #1;
      check("t4_high_addr", mem_addr, 32'hFFFF_FFFC);
      expQ.push_back(32'hFFFF_FFFC); expQ.push_back(32'h0); expQ.push_back(32'h4);
      mem_ready = 1'b1;
      drain("t4", 40);
      check("t4_issue0", issued[0], 32'hFFFF_FFFC);
      check("t4_issue1_wrap", issued[1], 32'h0);

      // 5: branch coincident with return and handshake, second branch next cycle
      resetCycle();
      memLat = 2; stall = 1'b0;
      expQ.push_back(32'h300); expQ.push_back(32'h304); expQ.push_back(32'h308);
      repeat (3) begin @(posedge CLK); #2; end
      branch_taken = 1'b1; branch_target = 32'h200; #1;
      check("t5_hs_branch1", 32'(mem_rd_req), 32'd1);
      @(posedge CLK); #2;
      branch_target = 32'h300; #1;
      check("t5_hs_branch2", 32'(mem_rd_req), 32'd1);
      check("t5_addr_branch2", mem_addr, 32'h200);
      @(posedge CLK); #2;
      branch_taken = 1'b0;
      drain("t5", 40);

      // 6: asynchronous reset mid-burst, restart at reset vector
      resetCycle();
      memLat = 1;
      repeat (4) begin @(negedge CLK); #1; end
      check("t6_pre_valid", 32'(instruction_valid), 32'd1);
      check("t6_pre_req", 32'(mem_rd_req), 32'd1);
      @(negedge CLK); #2;
      RSTb = 1'b1; #1;
      checkResetOutputs("t6_rst");
      repeat (2) begin @(posedge CLK); #2; end
      RSTb = 1'b0;
      expQ.push_back(32'h0); expQ.push_back(32'h4); expQ.push_back(32'h8);
      drain("t6", 40);
      check("t6_restart_addr", issued[0], 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
